// File: rtl/byte_serial_add_ctrl.sv
// ---------------------------------------------------------------------------
// byte_serial_add_ctrl
//
// Operand sequencer for an external 8-bit ripple-carry adder stage. It takes
// a wide A/B operand pair, feeds the adder one byte pair per cycle (LSB
// first) together with the running carry, and assembles the adder's sum
// bytes into a wide result with a final carry-out and signed overflow flag.
// Subtract is done as A + ~B + 1.
//
// Ports:
//   clk, rst            clock; asynchronous active-high reset
//   in_valid/in_ready   operand handshake (A, B, Cin, sub sampled on accept)
//   A, B                operands, W = 8*NBYTES bits
//   Cin                 carry-in, used in add mode only
//   sub                 1: A - B, 0: A + B + Cin
//   add_x, add_y        byte pair driven to the external adder (0 when idle)
//   add_ci              carry driven to the external adder (0 when idle)
//   add_s, add_co       adder response, combinational in the same cycle
//   out_valid/out_ready result handshake
//   S, Cout, ovf        result, final carry (sub: 1 = no borrow), overflow
//
// Handshake rule (both sides): a transfer happens on a rising clock edge
// where valid and ready are both 1. valid never depends on ready. in_ready is
// high only in IDLE and out_valid only in DONE, so an accept and a result
// handoff can never share a cycle.
// ---------------------------------------------------------------------------
module byte_serial_add_ctrl #(
  parameter int NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [8*NBYTES-1:0]   A,
  input  logic [8*NBYTES-1:0]   B,
  input  logic                  Cin,
  input  logic                  sub,
  output logic [7:0]            add_x,
  output logic [7:0]            add_y,
  output logic                  add_ci,
  input  logic [7:0]            add_s,
  input  logic                  add_co,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [8*NBYTES-1:0]   S,
  output logic                  Cout,
  output logic                  ovf
);

  localparam int W  = 8 * NBYTES;
  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // FSM state is kept as a plain named enum register so checkers can bind to
  // it directly.
  state_t         state;
  logic [IW-1:0]  idx;
  logic           carry;
  logic [W-1:0]   opA;
  logic [W-1:0]   opB;
  logic           last_byte;

  assign last_byte = (int'(idx) == NBYTES - 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
      carry <= 1'b0;
      opA   <= '0;
      opB   <= '0;
      S     <= '0;
      Cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            // Subtract is A + ~B + 1; Cin is not used in that mode.
            opA   <= A;
            opB   <= sub ? ~B : B;
            carry <= sub ? 1'b1 : Cin;
            idx   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          for (int k = 0; k < NBYTES; k++) begin
            if (int'(idx) == k) S[8*k +: 8] <= add_s;
          end
          carry <= add_co;
          if (last_byte) begin
            // Overflow: both addends share a sign that the top sum byte lost.
            Cout  <= add_co;
            ovf   <= (opA[W-1] == opB[W-1]) && (add_s[7] != opA[W-1]);
            idx   <= '0;
            state <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // in_ready is also forced low while rst is held so that every output reads
  // 0 during reset; it rises as soon as rst is released.
  assign in_ready  = (state == IDLE) && !rst;
  assign out_valid = (state == DONE);

  assign add_x  = (state == RUN) ? opA[{idx, 3'b000} +: 8] : 8'd0;
  assign add_y  = (state == RUN) ? opB[{idx, 3'b000} +: 8] : 8'd0;
  assign add_ci = (state == RUN) ? carry : 1'b0;

endmodule

// File: tb/tb_byte_serial_add_ctrl.sv
// ---------------------------------------------------------------------------
// Testbench for byte_serial_add_ctrl (NBYTES = 4). The external 8-bit adder
// is modelled as a combinational add. Expected results come from plain
// wide arithmetic on the original operands.
// ---------------------------------------------------------------------------
module tb_byte_serial_add_ctrl;

  localparam int NB = 4;
  localparam int W  = 8 * NB;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  A = '0;
  logic [W-1:0]  B = '0;
  logic          Cin = 1'b0;
  logic          sub = 1'b0;
  logic [7:0]    add_x;
  logic [7:0]    add_y;
  logic          add_ci;
  logic [7:0]    add_s;
  logic          add_co;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  S;
  logic          Cout;
  logic          ovf;

  // External 8-bit ripple-carry adder stage.
  assign {add_co, add_s} = {1'b0, add_x} + {1'b0, add_y} + {8'd0, add_ci};

  byte_serial_add_ctrl #(.NBYTES(NB)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .Cin       (Cin),
    .sub       (sub),
    .add_x     (add_x),
    .add_y     (add_y),
    .add_ci    (add_ci),
    .add_s     (add_s),
    .add_co    (add_co),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .S         (S),
    .Cout      (Cout),
    .ovf       (ovf)
  );

  int vectors    = 0;
  int miscompares = 0;

  // Expected-result queue: {ovf, Cout, S} pushed by the model, popped on check.
  logic [W+1:0] exp_q[$];

  // Observations gathered by drive_op.
  logic        obs_ready;
  int          obs_lat;
  logic [7:0]  obs_x [NB];
  logic [7:0]  obs_y [NB];
  logic        obs_c [NB];
  logic [W-1:0] obs_s;
  logic        obs_co;
  logic        obs_ov;

  // ---------------- reference model ----------------
  function automatic logic [W+1:0] ref_result(input logic [W-1:0] a, b,
                                              input logic cin, sb);
    logic [W:0] full;
    longint     sa, sbv, r;
    logic       ov;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    if (sb) begin
      full = {1'b0, a} - {1'b0, b};
      full[W] = (a >= b);          // carry-out means no borrow
      r = sa - sbv;
    end else begin
      full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
      r = sa + sbv + longint'(cin);
    end
    ov = (r > 64'sd2147483647) || (r < -64'sd2147483648);
    return {ov, full[W], full[W-1:0]};
  endfunction

  // Carry expected into byte k: carry out of the low k bytes of the operation.
  function automatic logic ref_carry_in(input logic [W-1:0] a, b,
                                        input logic cin, sb, input int k);
    longint unsigned m, la, lb;
    if (k == 0) return sb ? 1'b1 : cin;
    m  = 64'd1 << (8 * k);
    la = longint'(a) % m;
    lb = longint'(b) % m;
    if (sb) return (la >= lb);
    return ((la + lb + longint'(cin)) >= m);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_op(input logic [W-1:0] a, b, input logic cin, sb);
    @(negedge clk);
    A = a; B = b; Cin = cin; sub = sb; in_valid = 1'b1;
    obs_ready = in_ready;
    @(posedge clk);
    @(negedge clk);
    // Scramble inputs after the accept edge; they must have no effect.
    in_valid = 1'b0;
    A = $urandom; B = $urandom;
    Cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
    obs_lat = 0;
    while (!out_valid && obs_lat < 20) begin
      if (obs_lat < NB) begin
        obs_x[obs_lat] = add_x;
        obs_y[obs_lat] = add_y;
        obs_c[obs_lat] = add_ci;
      end
      @(posedge clk);
      obs_lat++;
      @(negedge clk);
    end
    obs_s = S; obs_co = Cout; obs_ov = ovf;
  endtask

  task automatic finish_op();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    @(negedge clk);
    vectors++;
    if ({out_valid, S, Cout, ovf, add_x, add_y, add_ci} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got out_valid=%b S=%h Cout=%b ovf=%b x=%h y=%h ci=%b, want all 0",
               out_valid, S, Cout, ovf, add_x, add_y, add_ci);
    end
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_arith();
    logic [W-1:0] ta [6] = '{32'h000000FF, 32'hFFFFFFFF, 32'd5, 32'd7,
                             32'h7FFFFFFF, 32'h80000000};
    logic [W-1:0] tb [6] = '{32'h00000001, 32'h00000000, 32'd7, 32'd5,
                             32'h00000001, 32'h00000001};
    logic         tc [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic         ts [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    for (int n = 0; n < 46; n++) begin
      logic [W-1:0] a, b;
      logic         c, s;
      logic [W+1:0] e;
      if (n < 6) begin
        a = ta[n]; b = tb[n]; c = tc[n]; s = ts[n];
      end else begin
        a = $urandom; b = $urandom;
        c = 1'($urandom_range(0, 1)); s = 1'($urandom_range(0, 1));
        if (n % 5 == 0) b = a;                       // equal-operand boundary
        if (n % 7 == 0) a = {1'b0, {(W-1){1'b1}}};   // max positive
      end
      exp_q.push_back(ref_result(a, b, c, s));
      drive_op(a, b, c, s);
      e = exp_q.pop_front();
      vectors++;
      if (obs_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL op%0d_in_ready: got %b want 1", n, obs_ready);
      end
      vectors++;
      if (obs_lat != NB) begin
        miscompares++;
        $display("FAIL op%0d_latency: got %0d edges want %0d", n, obs_lat, NB);
      end
      vectors++;
      if ({obs_ov, obs_co, obs_s} !== e) begin
        miscompares++;
        $display("FAIL op%0d_result A=%h B=%h Cin=%b sub=%b: got S=%h Cout=%b ovf=%b want S=%h Cout=%b ovf=%b",
                 n, a, b, c, s, obs_s, obs_co, obs_ov, e[W-1:0], e[W], e[W+1]);
      end
      for (int k = 0; k < NB && k < obs_lat; k++) begin
        logic [7:0] ex, ey;
        logic       ec;
        ex = 8'(a >> (8 * k));
        ey = s ? ~8'(b >> (8 * k)) : 8'(b >> (8 * k));
        ec = ref_carry_in(a, b, c, s, k);
        vectors++;
        if (obs_x[k] !== ex || obs_y[k] !== ey || obs_c[k] !== ec) begin
          miscompares++;
          $display("FAIL op%0d_byte%0d: got x=%h y=%h ci=%b want x=%h y=%h ci=%b",
                   n, k, obs_x[k], obs_y[k], obs_c[k], ex, ey, ec);
        end
      end
      finish_op();
    end
  endtask

  task automatic test_backpressure();
    logic [W+1:0] e;
    e = ref_result(32'hDEADBEEF, 32'h01234567, 1'b1, 1'b0);
    drive_op(32'hDEADBEEF, 32'h01234567, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      A = $urandom; B = $urandom;
      Cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
      vectors++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || {ovf, Cout, S} !== e) begin
        miscompares++;
        $display("FAIL bp_hold%0d: got out_valid=%b in_ready=%b S=%h Cout=%b ovf=%b want 1 0 S=%h Cout=%b ovf=%b",
                 i, out_valid, in_ready, S, Cout, ovf, e[W-1:0], e[W], e[W+1]);
      end
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    vectors++;
    if (in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_handshake_cycle_in_ready: got %b want 0", in_ready);
    end
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_release: got in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_reset_mid_run();
    @(negedge clk);
    A = 32'hAAAAAAAA; B = 32'h11111111; Cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);      // now working on byte 2
    #2 rst = 1'b1;
    #1;
    vectors++;
    if ({out_valid, S, Cout, ovf, add_x, add_y, add_ci, in_ready} !== '0) begin
      miscompares++;
      $display("FAIL mid_reset_outputs: got out_valid=%b S=%h Cout=%b ovf=%b x=%h y=%h ci=%b in_ready=%b, want all 0",
               out_valid, S, Cout, ovf, add_x, add_y, add_ci, in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    exp_q.push_back(ref_result(32'h12345678, 32'h11111111, 1'b0, 1'b0));
    drive_op(32'h12345678, 32'h11111111, 1'b0, 1'b0);
    vectors++;
    if (obs_s !== 32'h23456789 || {obs_ov, obs_co, obs_s} !== exp_q.pop_front()) begin
      miscompares++;
      $display("FAIL mid_reset_fresh_op: got S=%h Cout=%b ovf=%b want S=23456789 Cout=0 ovf=0",
               obs_s, obs_co, obs_ov);
    end
    finish_op();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_arith();
    test_backpressure();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
